// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared constants, FSM encoding and address-slicing helpers.
// Rev     : 1.0
// ============================================================================
package icache_pkg;

    // Instruction returned while the fetch stage is stalled (canonical nop).
    localparam logic [31:0] c_inst_nop = 32'h0000_0013;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic int offset_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_ram.sv
`default_nettype none
// ============================================================================
// Module  : icache_ram
// Brief   : Data and tag storage, combinational read, one synchronous write.
// Rev     : 1.0
// ============================================================================
module icache_ram #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int TAG_W = 24
) (
    input  logic                     clk,
    input  logic [$clog2(LINES)-1:0] i_rd_index,
    input  logic [$clog2(WORDS)-1:0] i_rd_word,
    output logic [31:0]              o_rd_data,
    output logic [TAG_W-1:0]         o_rd_tag,
    input  logic                     i_wr_en,
    input  logic                     i_wr_tag_en,
    input  logic [$clog2(LINES)-1:0] i_wr_index,
    input  logic [$clog2(WORDS)-1:0] i_wr_word,
    input  logic [31:0]              i_wr_data,
    input  logic [TAG_W-1:0]         i_wr_tag
);

    logic [31:0]      r_data [LINES*WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];

    // No reset: contents are qualified by the valid bits in the top level.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        if (i_wr_tag_en)
            r_tag[i_wr_index] <= i_wr_tag;
    end

    assign o_rd_data = r_data[{i_rd_index, i_rd_word}];
    assign o_rd_tag  = r_tag[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module  : icache
// Brief   : Direct-mapped read-only instruction cache with sequential refill.
// Rev     : 1.0
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mem_addr,
    output logic [31:0] i_mem_data,
    output logic        i_mem_stall,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int c_ob = offset_bits(WORDS);
    localparam int c_ib = index_bits(LINES);
    localparam int c_wb = c_ob - 2;
    localparam int c_tb = 32 - c_ob - c_ib;
    localparam logic [c_wb-1:0] c_last_beat = c_wb'(WORDS - 1);

    logic [1:0]        r_state;
    logic [31-c_ob:0]  r_line;
    logic [c_wb-1:0]   r_beat;
    logic [LINES-1:0]  r_valid;
    logic              r_inv_pending;

    logic [c_wb-1:0]   w_word;
    logic [c_ib-1:0]   w_index;
    logic [c_tb-1:0]   w_tag;
    logic [c_ib-1:0]   w_fill_index;
    logic [c_tb-1:0]   w_fill_tag;
    logic [31:0]       w_rd_data;
    logic [c_tb-1:0]   w_rd_tag;
    logic              w_hit;
    logic              w_ack;
    logic              w_last;
    logic              w_inv_eff;
    logic              w_unused;

    assign w_word       = i_mem_addr[c_ob-1:2];
    assign w_index      = i_mem_addr[c_ob+c_ib-1:c_ob];
    assign w_tag        = i_mem_addr[31:c_ob+c_ib];
    assign w_unused     = &{1'b0, i_mem_addr[1:0]};
    assign w_fill_index = r_line[c_ib-1:0];
    assign w_fill_tag   = r_line[31-c_ob:c_ib];

    assign w_hit = r_valid[w_index] && (w_rd_tag == w_tag) && (r_state == c_st_idle);

    // Stall is held low during reset and rises on the first lookup afterwards.
    assign i_mem_stall = !w_hit && !rst;
    assign i_mem_data  = w_hit ? w_rd_data : c_inst_nop;

    assign mem_req   = (r_state == c_st_fill);
    assign mem_addr  = mem_req ? {r_line, r_beat, 2'b00} : 32'd0;
    assign w_ack     = mem_req && mem_ack;
    assign w_last    = w_ack && (r_beat == c_last_beat);
    assign w_inv_eff = r_inv_pending || inv;

    icache_ram #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (c_tb)
    ) u_ram (
        .clk         (clk),
        .i_rd_index  (w_index),
        .i_rd_word   (w_word),
        .o_rd_data   (w_rd_data),
        .o_rd_tag    (w_rd_tag),
        .i_wr_en     (w_ack),
        .i_wr_tag_en (w_last && !w_inv_eff),
        .i_wr_index  (w_fill_index),
        .i_wr_word   (r_beat),
        .i_wr_data   (mem_rdata),
        .i_wr_tag    (w_fill_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_line        <= '0;
            r_beat        <= '0;
            r_valid       <= '0;
            r_inv_pending <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (inv)
                        r_valid <= '0;
                    if (!w_hit) begin
                        r_line  <= i_mem_addr[31:c_ob];
                        r_beat  <= '0;
                        r_state <= c_st_fill;
                    end
                end
                c_st_fill: begin
                    if (inv)
                        r_inv_pending <= 1'b1;
                    if (w_ack)
                        r_beat <= r_beat + 1'b1;
                    // An invalidate seen at any point of the fill discards the line.
                    if (w_last) begin
                        if (w_inv_eff) begin
                            r_valid       <= '0;
                            r_inv_pending <= 1'b0;
                        end else begin
                            r_valid[w_fill_index] <= 1'b1;
                        end
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (inv)
                        r_valid <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
